recebe_time_nivel2: RTL and testbench

//  Consumer end of the keypad time-entry interface. Receives the BCD digit stream (D, loadn strobe)

---
 rtl/time_pkg.sv | 11 +
 rtl/bcd_dec_digit.sv | 13 +
 rtl/recebe_time_nivel2.sv | 97 +++++++++
 tb/tb_recebe_time_nivel2.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/time_pkg.sv
// time_pkg: shared BCD widths, FSM state encoding and a BCD increment helper for the time-entry block.
package time_pkg;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  function automatic logic [7:0] bcd_inc2(input logic [7:0] v);
    return (v[3:0] == BCD_MAX) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction
endpackage

// File: rtl/bcd_dec_digit.sv
// bcd_dec_digit: one BCD countdown digit; borrows out and reloads wrap_i when decremented from zero.
module bcd_dec_digit
  import time_pkg::*;
(
  input  logic             en_i,
  input  logic [BCD_W-1:0] val_i,
  input  logic [BCD_W-1:0] wrap_i,
  output logic [BCD_W-1:0] val_o,
  output logic             bout_o
);
  assign bout_o = en_i & (val_i == '0);
  assign val_o  = !en_i ? val_i : bout_o ? wrap_i : val_i - 4'd1;
endmodule

// File: rtl/recebe_time_nivel2.sv
// recebe_time_nivel2: keypad MM:SS entry register with 1 Hz countdown and completion flag.
// NORMALIZE_SEC_EN: fold seconds >= 60 into minutes when a run starts.
module recebe_time_nivel2
  import time_pkg::*;
#(
  parameter logic [BCD_W-1:0] SEC_TENS_WRAP = 4'd5,
  parameter bit               SYNC_IN       = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [BCD_W-1:0] D,
  input  logic             loadn,
  input  logic             pgt_1Hz,
  input  logic             startn,
  input  logic             stopn,
  output logic [BCD_W-1:0] min_t,
  output logic [BCD_W-1:0] min_u,
  output logic [BCD_W-1:0] sec_t,
  output logic [BCD_W-1:0] sec_u,
  output logic             running,
  output logic             done
);
  logic [BCD_W-1:0] d_s;
  logic loadn_s, pgt_s, loadn_h_q, pgt_h_q, fall, rise;
  logic [1:0] st_q, st_d;
  logic [15:0] val_q, val_d, dec;
  logic [3:0] bout;
  if (SYNC_IN) begin : g_sync
    logic [BCD_W-1:0] d_q;
    logic loadn_q, pgt_q;
    always_ff @(posedge clk) begin
      if (clear) begin
        d_q <= '0;
        loadn_q <= 1'b1;
        pgt_q <= 1'b0;
      end else begin
        d_q <= D;
        loadn_q <= loadn;
        pgt_q <= pgt_1Hz;
      end
    end
    assign d_s = d_q;
    assign loadn_s = loadn_q;
    assign pgt_s = pgt_q;
  end else begin : g_direct
    assign d_s = D;
    assign loadn_s = loadn;
    assign pgt_s = pgt_1Hz;
  end
  assign fall = loadn_h_q & ~loadn_s;
  assign rise = ~pgt_h_q & pgt_s;
  // Countdown chain: seconds units borrow into tens, tens into minutes units, and so on.
  bcd_dec_digit u_su (.en_i(st_q == ST_RUN && rise), .val_i(val_q[3:0]), .wrap_i(BCD_MAX),
                      .val_o(dec[3:0]), .bout_o(bout[0]));
  bcd_dec_digit u_st (.en_i(bout[0]), .val_i(val_q[7:4]), .wrap_i(SEC_TENS_WRAP),
                      .val_o(dec[7:4]), .bout_o(bout[1]));
  bcd_dec_digit u_mu (.en_i(bout[1]), .val_i(val_q[11:8]), .wrap_i(BCD_MAX),
                      .val_o(dec[11:8]), .bout_o(bout[2]));
  bcd_dec_digit u_mt (.en_i(bout[2]), .val_i(val_q[15:12]), .wrap_i(BCD_MAX),
                      .val_o(dec[15:12]), .bout_o(bout[3]));
  always_comb begin
    st_d = st_q;
    val_d = val_q;
    if (!stopn) begin
      st_d = ST_IDLE;
      val_d = (st_q == ST_IDLE) ? '0 : val_q;
    end else if (!startn && st_q == ST_IDLE && val_q != '0) begin
      st_d = ST_RUN;
`ifdef NORMALIZE_SEC_EN
      if (val_q[7:4] >= 4'd6 && val_q[15:8] != 8'h99)
        val_d = {bcd_inc2(val_q[15:8]), val_q[7:4] - 4'd6, val_q[3:0]};
`endif
    end else if (st_q == ST_RUN && rise) begin
      val_d = dec;
      st_d = (dec == '0) ? ST_DONE : ST_RUN;
    end else if (st_q != ST_RUN && fall && d_s <= BCD_MAX) begin
      val_d = {val_q[11:0], d_s};
      st_d = ST_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (clear) begin
      st_q <= ST_IDLE;
      val_q <= '0;
      loadn_h_q <= 1'b1;
      pgt_h_q <= 1'b0;
    end else begin
      st_q <= st_d;
      val_q <= val_d;
      loadn_h_q <= loadn_s;
      pgt_h_q <= pgt_s;
    end
  end
  assign {min_t, min_u, sec_t, sec_u} = val_q;
  assign running = (st_q == ST_RUN);
  assign done = (st_q == ST_DONE);
endmodule

// File: tb/tb_recebe_time_nivel2.sv
// tb_recebe_time_nivel2: directed scoreboard bench; expectations are queued by stimulus and checked on negedge.
module tb_recebe_time_nivel2;
  typedef struct {
    string nm;
    int t;
    logic [15:0] v;
    logic r;
    logic d;
  } exp_t;
  logic clk = 1'b0, clear = 1'b1, loadn = 1'b1, pgt = 1'b0, startn = 1'b1, stopn = 1'b1;
  logic [3:0] d_in = 4'd0;
  logic [3:0] min_t, min_u, sec_t, sec_u;
  logic running, done;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  exp_t q[$];
  recebe_time_nivel2 #(.SEC_TENS_WRAP(4'd5), .SYNC_IN(1'b0)) dut (
    .clk(clk), .clear(clear), .D(d_in), .loadn(loadn), .pgt_1Hz(pgt),
    .startn(startn), .stopn(stopn), .min_t(min_t), .min_u(min_u),
    .sec_t(sec_t), .sec_u(sec_u), .running(running), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    while (q.size() != 0 && q[0].t <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if ({min_t, min_u, sec_t, sec_u, running, done} !== {e.v, e.r, e.d}) begin
        n_bad++;
        $display("FAIL %s: got %h run=%b done=%b, want %h run=%b done=%b",
                 e.nm, {min_t, min_u, sec_t, sec_u}, running, done, e.v, e.r, e.d);
      end
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic expect_now(input string nm, input logic [15:0] v, input logic r, input logic d);
    q.push_back('{nm, cyc, v, r, d});
  endtask
  task automatic key(input logic [3:0] k);
    d_in = k;
    loadn = 1'b0;
    step(1);
    loadn = 1'b1;
    step(1);
  endtask
  task automatic tick();
    pgt = 1'b1;
    step(1);
    pgt = 1'b0;
    step(1);
  endtask
  task automatic start();
    startn = 1'b0;
    step(1);
    startn = 1'b1;
    step(1);
  endtask
  task automatic stop();
    stopn = 1'b0;
    step(1);
    stopn = 1'b1;
    step(1);
  endtask
  initial begin
    int w;
    step(2);
    expect_now("reset", 16'h0000, 1'b0, 1'b0);
    clear = 1'b0;
    step(1);
    key(4'd1); key(4'd3); key(4'd0);
    expect_now("load_0130", 16'h0130, 1'b0, 1'b0);
    key(4'd12);
    expect_now("bad_digit", 16'h0130, 1'b0, 1'b0);
    stop();
    expect_now("idle_stop_clr", 16'h0000, 1'b0, 1'b0);
    key(4'd0); key(4'd2);
    start();
    expect_now("start_0002", 16'h0002, 1'b1, 1'b0);
    tick();
    expect_now("tick_0001", 16'h0001, 1'b1, 1'b0);
    tick();
    expect_now("tick_done", 16'h0000, 1'b0, 1'b1);
    tick();
    expect_now("done_tick_ign", 16'h0000, 1'b0, 1'b1);
    key(4'd5);
    expect_now("done_capture", 16'h0005, 1'b0, 1'b0);
    stop();
    key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    start();
    expect_now("start_1000", 16'h1000, 1'b1, 1'b0);
    tick();
    expect_now("dbl_borrow", 16'h0959, 1'b1, 1'b0);
    stop();
    expect_now("pause", 16'h0959, 1'b0, 1'b0);
    stop();
    expect_now("cancel", 16'h0000, 1'b0, 1'b0);
    start();
    expect_now("start_zero", 16'h0000, 1'b0, 1'b0);
    key(4'd2); key(4'd0);
    start();
    expect_now("start_0020", 16'h0020, 1'b1, 1'b0);
    key(4'd7);
    expect_now("run_key_ign", 16'h0020, 1'b1, 1'b0);
    pgt = 1'b1;
    stopn = 1'b0;
    step(1);
    pgt = 1'b0;
    stopn = 1'b1;
    step(1);
    expect_now("tick_stop", 16'h0020, 1'b0, 1'b0);
    startn = 1'b0;
    stopn = 1'b0;
    step(1);
    startn = 1'b1;
    stopn = 1'b1;
    step(1);
    expect_now("start_stop", 16'h0000, 1'b0, 1'b0);
    key(4'd1); key(4'd0); key(4'd0);
    start();
    tick();
    expect_now("min_borrow", 16'h0059, 1'b1, 1'b0);
    stop(); stop();
    key(4'd1); key(4'd7); key(4'd5);
    start();
`ifdef NORMALIZE_SEC_EN
    expect_now("norm_start", 16'h0215, 1'b1, 1'b0);
    tick();
    expect_now("norm_tick", 16'h0214, 1'b1, 1'b0);
`else
    expect_now("raw_start", 16'h0175, 1'b1, 1'b0);
    tick();
    expect_now("raw_tick", 16'h0174, 1'b1, 1'b0);
`endif
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    expect_now("clear_run", 16'h0000, 1'b0, 1'b0);
    w = 0;
    while (q.size() != 0 && w < 10) begin
      step(1);
      w++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d checks pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
